// File: rtl/frame_loader_pkg.sv
// rtl/frame_loader_pkg.sv - shared state type, header sync word and header field layout
package frame_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  localparam logic [7:0] HDR_SYNC     = 8'hC5;
  localparam int         HDR_SYNC_MSB = 31;
  localparam int         HDR_SYNC_LSB = 24;
  localparam int         HDR_IDX_MSB  = 4;
  localparam int         HDR_IDX_LSB  = 0;
  localparam int         IDX_W        = HDR_IDX_MSB - HDR_IDX_LSB + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_strobe_dec.sv
// rtl/frame_strobe_dec.sv - one-hot frame strobe decoder, enabled only while strobing
module frame_strobe_dec
  import frame_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = 20
) (
  input  logic [IDX_W-1:0]           idx_i,
  input  logic                       en_i,
  output logic [MaxFramesPerCol-1:0] strobe_o
);

  always_comb begin
    strobe_o = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      strobe_o[i] = en_i && (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - header/data word loader driving one column's FrameData and FrameStrobe
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeLen       = 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic [15:0]                frame_cnt
);

  state_e                     state_q;
  logic                       s_ready_q;
  logic [IDX_W-1:0]           idx_q;
  logic [FrameBitsPerRow-1:0] frame_data_q;
  logic [3:0]                 strobe_cnt_q;
  logic                       err_q;
  logic [15:0]                frame_cnt_q;

  logic [IDX_W-1:0] hdr_idx;
  logic             hdr_ok;
  logic             accept;
  logic             strobe_last;

  assign hdr_idx     = s_data[HDR_IDX_MSB:HDR_IDX_LSB];
  assign hdr_ok      = (s_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == HDR_SYNC) &&
                       (32'(hdr_idx) < 32'(MaxFramesPerCol));
  assign accept      = s_valid && s_ready_q;
  assign strobe_last = (strobe_cnt_q == 4'(StrobeLen - 1));

  // clr is applied first so that a same-edge error or increment overrides it
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      idx_q        <= '0;
      frame_data_q <= '0;
      strobe_cnt_q <= '0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      if (clr) begin
        err_q       <= 1'b0;
        frame_cnt_q <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (hdr_ok) begin
              idx_q   <= hdr_idx;
              state_q <= ST_DATA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            frame_data_q <= s_data;
            s_ready_q    <= 1'b0;
            state_q      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          strobe_cnt_q <= '0;
          state_q      <= ST_STROBE;
        end
        ST_STROBE: begin
          if (strobe_last) begin
            strobe_cnt_q <= '0;
            frame_cnt_q  <= sat_inc16(frame_cnt_q);
            state_q      <= ST_HOLD;
          end else begin
            strobe_cnt_q <= strobe_cnt_q + 4'd1;
          end
        end
        ST_HOLD: begin
          s_ready_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          s_ready_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // strobe decodes straight from registered state/index, so reset clears it asynchronously
  frame_strobe_dec #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_strobe_dec (
    .idx_i   (idx_q),
    .en_i    (state_q == ST_STROBE),
    .strobe_o(FrameStrobe)
  );

  assign s_ready   = s_ready_q;
  assign FrameData = frame_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter FrameBitsPerRow, default 32: width of the configuration data word and of FrameData.
REQ-002 Parameter MaxFramesPerCol, default 20: number of frame strobe lines driven.
REQ-003 Parameter StrobeLen, default 1, legal 1..15: cycles FrameStrobe stays high per frame.
REQ-004 UserCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset; asynchronous assertion, active-low.
REQ-006 s_data  input  FrameBitsPerRow  incoming header or data word.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  block accepts a word; transfer occurs on an edge with s_valid=1 and s_ready=1.
REQ-009 clr  input  1  synchronous clear of err and frame_cnt.
REQ-010 FrameData  output  FrameBitsPerRow  registered frame word feeding the column's FrameData chain.
REQ-011 FrameStrobe  output  MaxFramesPerCol  registered one-hot frame strobe feeding the column's FrameStrobe chain.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  sticky error flag.
REQ-014 frame_cnt  output  16  count of frames strobed.

Function
REQ-015 FSM states: IDLE, DATA, SETUP, STROBE, HOLD.
REQ-016 IDLE: s_ready=1; an accepted word is a header; valid header = s_data[31:24]==8'hC5 and s_data[4:0]<MaxFramesPerCol; valid header latches frame index, goes to DATA.
REQ-017 Invalid header in IDLE: word dropped, err set, state stays IDLE.
REQ-018 DATA: s_ready=1; accepted word loaded into FrameData on the same edge; state goes to SETUP.
REQ-019 SETUP: s_ready=0, FrameStrobe all zero, one cycle; gives FrameData one full cycle of setup before strobe.
REQ-020 STROBE: FrameStrobe[index]=1, all other bits 0, for exactly StrobeLen cycles, timed by a 4-bit counter; then HOLD.
REQ-021 HOLD: FrameStrobe all zero, FrameData unchanged, s_ready=0, one cycle; then IDLE.
REQ-022 FrameData changes only on a DATA-state accept or reset; held otherwise.
REQ-023 Latency: data accepted at edge k -> FrameData valid after k, strobe high after k+1 through k+1+StrobeLen, s_ready high again after k+2+StrobeLen.
REQ-024 frame_cnt increments on the STROBE->HOLD transition and saturates at 16'hFFFF.
REQ-025 clr=1: err and frame_cnt cleared; simultaneous error set or increment wins over clr.
REQ-026 s_valid=0 in IDLE/DATA: state holds indefinitely; no timeout.
REQ-027 s_data is ignored whenever s_ready=0.

Reset
REQ-028 resetn low: state IDLE, FrameData=0, FrameStrobe=0, err=0, frame_cnt=0, strobe counter=0, s_ready=0, busy=0.
REQ-029 Reset mid-operation, including during STROBE: FrameStrobe drops to 0 asynchronously; no partial frame is counted.
REQ-030 s_ready rises to 1 on the first edge after resetn deasserts.

Structure
REQ-031 Package frame_loader_pkg holds the state enum, the sync constant 8'hC5, and the header field positions [31:24] and [4:0].
REQ-032 One sub-module frame_strobe_dec holds the registered-index to one-hot decoder, gated by the STROBE state.

Verification
REQ-033 Header 32'hC5000003 then data 32'hDEADBEEF, StrobeLen=1 -> FrameData=DEADBEEF; FrameStrobe=20'h00008 for one cycle, one cycle after data accept; frame_cnt=1.
REQ-034 Header 32'h12000003 -> err=1, no strobe; then valid header and data -> normal frame, err still 1.
REQ-035 Header with index 20 (32'hC5000014) -> err=1, s_ready stays 1, state IDLE.
REQ-036 StrobeLen=3, index 19 -> FrameStrobe[19] high exactly 3 cycles; s_valid held high throughout is back-pressured until HOLD ends.
REQ-037 resetn pulled low during STROBE -> FrameStrobe=0 immediately, frame_cnt unchanged; next full header/data pair completes normally.
REQ-038 clr asserted on the same cycle frame_cnt increments -> frame_cnt shows the increment; clr alone next cycle -> frame_cnt=0, err=0.
